// File: rtl/diamond_sym_gen.sv
// Streams the PAD/NUM/EOL layout symbols of a size-n number diamond over a valid/ready handshake.
// Rows run 1..n then n-1..1; row i is (n-i) PADs, i NUM(i) symbols and one EOL.
module diamond_sym_gen #(
  parameter int unsigned NW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_sym,
  output logic [NW-1:0] out_val,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] SymPad = 2'b00;
  localparam logic [1:0] SymNum = 2'b01;
  localparam logic [1:0] SymEol = 2'b10;

  typedef enum logic [2:0] {StIdle, StPad, StNum, StEol, StFin} state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] row_q, row_d;
  logic [NW-1:0] col_q, col_d;
  logic          dir_q, dir_d;  // 0 = rows growing, 1 = rows shrinking

  logic          fire;
  logic [NW-1:0] pad_len;
  logic [NW:0]   col_inc;
  logic [NW-1:0] row_nxt;
  logic          dir_nxt;

  assign fire    = out_valid && out_ready;
  assign pad_len = n_q - row_q;  // row never exceeds n_q, so no underflow
  assign col_inc = {1'b0, col_q} + (NW+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
    end
  end

  // Row that follows the current one once its EOL is taken; 0 means the diamond is finished.
  always_comb begin
    row_nxt = '0;
    dir_nxt = dir_q;
    if (!dir_q && (row_q != n_q)) begin
      row_nxt = row_q + NW'(1);
    end else if (!dir_q) begin
      dir_nxt = 1'b1;
      row_nxt = n_q - NW'(1);
    end else begin
      row_nxt = row_q - NW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d   = n;
          row_d = NW'(1);
          col_d = '0;
          dir_d = 1'b0;
          if (n == '0) begin
            state_d = StFin;
          end else if (n != NW'(1)) begin
            state_d = StPad;
          end else begin
            state_d = StNum;
          end
        end
      end
      StPad: begin
        if (fire) begin
          if (col_inc == {1'b0, pad_len}) begin
            state_d = StNum;
            col_d   = '0;
          end else begin
            col_d = col_inc[NW-1:0];
          end
        end
      end
      StNum: begin
        if (fire) begin
          if (col_inc == {1'b0, row_q}) begin
            state_d = StEol;
            col_d   = '0;
          end else begin
            col_d = col_inc[NW-1:0];
          end
        end
      end
      StEol: begin
        if (fire) begin
          col_d = '0;
          dir_d = dir_nxt;
          row_d = row_nxt;
          if (row_nxt == '0) begin
            state_d = StFin;
          end else if (row_nxt != n_q) begin
            state_d = StPad;
          end else begin
            state_d = StNum;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode the state register only, so out_ready never reaches out_valid.
  always_comb begin
    out_valid = 1'b0;
    out_sym   = SymPad;
    out_val   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StPad: begin
        out_valid = 1'b1;
        out_sym   = SymPad;
        busy      = 1'b1;
      end
      StNum: begin
        out_valid = 1'b1;
        out_sym   = SymNum;
        out_val   = row_q;
        busy      = 1'b1;
      end
      StEol: begin
        out_valid = 1'b1;
        out_sym   = SymEol;
        busy      = 1'b1;
      end
      StFin: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_diamond_sym_gen.sv
// Randomized bench for diamond_sym_gen; expected symbol streams come from a row-list model.
module tb_diamond_sym_gen;

  localparam int unsigned NW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] n;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_sym;
  logic [NW-1:0] out_val;
  logic          busy;
  logic          done;

  diamond_sym_gen #(.NW(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n         (n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_val   (out_val),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  logic [NW+1:0] exp_q[$];
  logic [NW+1:0] obs_q[$];
  int            done_cyc;
  int            stall_err;
  int            bubbles;
  bit            timeout;
  logic          busy_after;
  logic          done_after;
  logic          valid_after;

  // Reference: list the rows, then lay out each one as PADs, NUMs and an EOL.
  task automatic build_expected(input int nn);
    int rows[$];
    exp_q.delete();
    for (int i = 1; i <= nn; i++) rows.push_back(i);
    for (int i = nn - 1; i >= 1; i--) rows.push_back(i);
    foreach (rows[r]) begin
      for (int k = 0; k < nn - rows[r]; k++) exp_q.push_back({2'b00, 4'd0});
      for (int k = 0; k < rows[r]; k++) exp_q.push_back({2'b01, 4'(rows[r])});
      exp_q.push_back({2'b10, 4'd0});
    end
  endtask

  function automatic int first_diff();
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Drives one request and records every accepted symbol; stop_after > 0 abandons it early.
  task automatic run_pattern(input int nn, input bit rnd_ready, input bit noise_start,
                             input int stop_after);
    logic [NW+1:0] prev_sym;
    bit            prev_stall;
    int            bound;
    int            cyc;
    obs_q.delete();
    done_cyc   = -1;
    stall_err  = 0;
    bubbles    = 0;
    timeout    = 0;
    prev_stall = 0;
    prev_sym   = '0;
    bound      = 4 * (2 * nn + 1) * (nn + 1) + 20;
    @(negedge clk);
    start     = 1'b1;
    n         = 4'(nn);
    out_ready = 1'b1;
    @(posedge clk);
    cyc = 1;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (stop_after > 0 && cyc >= stop_after) break;
      if (cyc > bound) begin
        timeout = 1;
        break;
      end
      if (out_valid) begin
        if (prev_stall && ({out_sym, out_val} !== prev_sym)) stall_err++;
      end else begin
        bubbles++;
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise_start) begin
        start = 1'($urandom_range(0, 1));
        n     = 4'd3;
      end
      prev_stall = out_valid && !out_ready;
      prev_sym   = {out_sym, out_val};
      if (out_valid && out_ready) obs_q.push_back({out_sym, out_val});
      @(posedge clk);
      cyc++;
    end
    if (done_cyc >= 0) begin
      start = noise_start;
      n     = 4'd3;
      @(posedge clk);
      @(negedge clk);
      start       = 1'b0;
      busy_after  = busy;
      done_after  = done;
      valid_after = out_valid;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    n         = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {busy, done});
    else n_pass++;
    n_checks++;
    if ({out_sym, out_val} !== 6'd0) $display("FAIL reset_sym_val: got %h want 0", {out_sym, out_val});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_n5_ready();
    build_expected(5);
    run_pattern(5, 0, 0, 0);
    n_checks++;
    if (obs_q.size() != 54) $display("FAIL n5_count: got %0d want 54", obs_q.size());
    else n_pass++;
    n_checks++;
    if (first_diff() != -1) $display("FAIL n5_seq: diff at %0d want -1", first_diff());
    else n_pass++;
    n_checks++;
    if (done_cyc != 55) $display("FAIL n5_done_cyc: got %0d want 55", done_cyc);
    else n_pass++;
    n_checks++;
    if (bubbles != 0) $display("FAIL n5_bubbles: got %0d want 0", bubbles);
    else n_pass++;
    n_checks++;
    if ({busy_after, done_after, valid_after} !== 3'b000)
      $display("FAIL n5_after: got %b want 000", {busy_after, done_after, valid_after});
    else n_pass++;
  endtask

  task automatic test_small();
    build_expected(1);
    run_pattern(1, 0, 0, 0);
    n_checks++;
    if (first_diff() != -1) $display("FAIL n1_seq: diff at %0d want -1", first_diff());
    else n_pass++;
    n_checks++;
    if (done_cyc != 3) $display("FAIL n1_done_cyc: got %0d want 3", done_cyc);
    else n_pass++;
    build_expected(0);
    run_pattern(0, 0, 0, 0);
    n_checks++;
    if (obs_q.size() != 0 || bubbles != 0)
      $display("FAIL n0_symbols: got %0d syms want 0", obs_q.size());
    else n_pass++;
    n_checks++;
    if (done_cyc != 1) $display("FAIL n0_done_cyc: got %0d want 1", done_cyc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    build_expected(5);
    run_pattern(5, 1, 0, 0);
    n_checks++;
    if (first_diff() != -1) $display("FAIL bp_seq: diff at %0d want -1", first_diff());
    else n_pass++;
    n_checks++;
    if (stall_err != 0) $display("FAIL bp_stable: got %0d changes want 0", stall_err);
    else n_pass++;
    n_checks++;
    if (bubbles != 0 || timeout) $display("FAIL bp_valid_drop: got %0d want 0", bubbles);
    else n_pass++;
  endtask

  task automatic test_n15();
    int num15;
    build_expected(15);
    run_pattern(15, 0, 0, 0);
    num15 = 0;
    foreach (obs_q[i]) if (obs_q[i] === {2'b01, 4'd15}) num15++;
    n_checks++;
    if (obs_q.size() != 464) $display("FAIL n15_count: got %0d want 464", obs_q.size());
    else n_pass++;
    n_checks++;
    if (first_diff() != -1) $display("FAIL n15_seq: diff at %0d want -1", first_diff());
    else n_pass++;
    n_checks++;
    if (num15 != 15) $display("FAIL n15_middle: got %0d want 15", num15);
    else n_pass++;
    n_checks++;
    if (done_cyc != 465) $display("FAIL n15_done_cyc: got %0d want 465", done_cyc);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    build_expected(5);
    run_pattern(5, 1, 1, 0);
    n_checks++;
    if (first_diff() != -1) $display("FAIL ign_seq: diff at %0d want -1", first_diff());
    else n_pass++;
    n_checks++;
    if (busy_after !== 1'b0) $display("FAIL ign_fin_start: busy got %b want 0", busy_after);
    else n_pass++;
  endtask

  task automatic test_reset_midrow();
    run_pattern(5, 0, 0, 16);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL async_reset: got %b want 000", {out_valid, busy, done});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    build_expected(2);
    run_pattern(2, 0, 0, 0);
    n_checks++;
    if (first_diff() != -1) $display("FAIL post_reset_seq: diff at %0d want -1", first_diff());
    else n_pass++;
    n_checks++;
    if (done_cyc != 10) $display("FAIL post_reset_done: got %0d want 10", done_cyc);
    else n_pass++;
  endtask

  task automatic test_random();
    int nn;
    for (int t = 0; t < 6; t++) begin
      nn = $urandom_range(0, 9);
      build_expected(nn);
      run_pattern(nn, 1, 0, 0);
      n_checks++;
      if (first_diff() != -1 || stall_err != 0 || timeout)
        $display("FAIL rand_n%0d: diff %0d stall %0d want -1/0", nn, first_diff(), stall_err);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_n5_ready();
    test_small();
    test_backpressure();
    test_n15();
    test_start_ignored();
    test_reset_midrow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
